// File: rtl/seq_event_arbiter.sv
// Latches hit pulses from three detector lanes and offers them one at a time on a shared
// valid/ready event channel, arbitrating round-robin; also keeps per-lane hit statistics.
module seq_event_arbiter #(
    parameter int unsigned NUM_LANES = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] lane_en,
    input  logic [NUM_LANES-1:0] det_pulse,
    input  logic                 ev_ready,
    output logic                 ev_valid,
    output logic [1:0]           ev_lane,
    output logic                 any_hit,
    input  logic [1:0]           cnt_sel,
    output logic [CNT_W-1:0]     cnt_value,
    input  logic                 cnt_clear,
    output logic [NUM_LANES-1:0] ovf_flags
);

    typedef enum logic {StIdle, StOffer} state_t;

    state_t               state;
    logic [NUM_LANES-1:0] pending;
    logic [NUM_LANES-1:0] hit;
    logic [NUM_LANES-1:0] grant_mask;
    logic [NUM_LANES-1:0] ovf_set;
    logic [1:0]           last_grant;
    logic [1:0]           cand1, cand2, cand3, winner;
    logic                 grant;
    logic [CNT_W-1:0]     cnt [NUM_LANES];

    function automatic logic [1:0] next_lane(input logic [1:0] lane);
        return (lane == 2'd2) ? 2'd0 : lane + 2'd1;
    endfunction

    always_comb begin
        hit   = det_pulse & lane_en;
        cand1 = next_lane(last_grant);
        cand2 = next_lane(cand1);
        cand3 = next_lane(cand2);
        if (pending[cand1]) begin
            winner = cand1;
        end else if (pending[cand2]) begin
            winner = cand2;
        end else begin
            winner = cand3;
        end
        grant      = (state == StIdle) && (pending != '0);
        grant_mask = grant ? (NUM_LANES'(1) << winner) : '0;
        // A hit landing on its own lane's grant edge just re-arms the pending bit.
        ovf_set    = hit & pending & ~grant_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            ev_valid   <= 1'b0;
            ev_lane    <= 2'd0;
            last_grant <= 2'd2;
            pending    <= '0;
            any_hit    <= 1'b0;
        end else begin
            any_hit <= |hit;
            pending <= (pending & ~grant_mask) | hit;
            case (state)
                StIdle: begin
                    if (grant) begin
                        ev_lane  <= winner;
                        ev_valid <= 1'b1;
                        state    <= StOffer;
                    end
                end
                StOffer: begin
                    if (ev_ready) begin
                        ev_valid   <= 1'b0;
                        last_grant <= ev_lane;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) cnt[i] <= '0;
            ovf_flags <= '0;
        end else if (cnt_clear) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) cnt[i] <= '0;
            ovf_flags <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (hit[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
            end
            ovf_flags <= ovf_flags | ovf_set;
        end
    end

    always_comb begin
        case (cnt_sel)
            2'd0:    cnt_value = cnt[0];
            2'd1:    cnt_value = cnt[1];
            2'd2:    cnt_value = cnt[2];
            default: cnt_value = '0;
        endcase
    end

endmodule

// File: tb/tb_seq_event_arbiter.sv
// Directed bench for seq_event_arbiter: latency, round-robin order, stall/overflow,
// lane enable, counter saturation/clear and asynchronous reset mid-offer.
module tb_seq_event_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] lane_en;
    logic [2:0] det_pulse;
    logic       ev_ready;
    logic       ev_valid;
    logic [1:0] ev_lane;
    logic       any_hit;
    logic [1:0] cnt_sel;
    logic [7:0] cnt_value;
    logic       cnt_clear;
    logic [2:0] ovf_flags;

    int passed = 0;
    int total  = 0;

    seq_event_arbiter #(.NUM_LANES(3), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .lane_en   (lane_en),
        .det_pulse (det_pulse),
        .ev_ready  (ev_ready),
        .ev_valid  (ev_valid),
        .ev_lane   (ev_lane),
        .any_hit   (any_hit),
        .cnt_sel   (cnt_sel),
        .cnt_value (cnt_value),
        .cnt_clear (cnt_clear),
        .ovf_flags (ovf_flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        det_pulse = 3'b000;
        cnt_clear = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        lane_en  = 3'b111;
        ev_ready = 1'b0;
        cnt_sel  = 2'd0;
        apply_reset();
        total++;
        if ({ev_valid, ev_lane, any_hit, ovf_flags} !== 7'b0) begin
            $display("FAIL reset_outputs: got v=%b l=%0d ah=%b ovf=%b, want all 0",
                     ev_valid, ev_lane, any_hit, ovf_flags);
        end else passed++;
        for (int i = 0; i < 3; i++) begin
            cnt_sel = 2'(i);
            #1;
            total++;
            if (cnt_value !== 8'd0) begin
                $display("FAIL reset_cnt%0d: got %0d, want 0", i, cnt_value);
            end else passed++;
        end
    endtask

    task automatic test_single();
        ev_ready  = 1'b1;
        det_pulse = 3'b001;
        tick();
        det_pulse = 3'b000;
        total++;
        if (ev_valid !== 1'b0 || any_hit !== 1'b1) begin
            $display("FAIL single_edge1: got v=%b ah=%b, want v=0 ah=1", ev_valid, any_hit);
        end else passed++;
        tick();
        total++;
        if (ev_valid !== 1'b1 || ev_lane !== 2'd0 || any_hit !== 1'b0) begin
            $display("FAIL single_offer: got v=%b l=%0d ah=%b, want v=1 l=0 ah=0",
                     ev_valid, ev_lane, any_hit);
        end else passed++;
        tick();
        total++;
        if (ev_valid !== 1'b0) begin
            $display("FAIL single_done: got v=%b, want 0", ev_valid);
        end else passed++;
        cnt_sel = 2'd0;
        #1;
        total++;
        if (cnt_value !== 8'd1) begin
            $display("FAIL single_cnt0: got %0d, want 1", cnt_value);
        end else passed++;
    endtask

    task automatic test_all_lanes();
        logic [2:0] exp_v [7];
        logic [1:0] exp_l [7];
        exp_v = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_l = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0};
        apply_reset();
        ev_ready  = 1'b1;
        det_pulse = 3'b111;
        for (int i = 0; i < 7; i++) begin
            tick();
            det_pulse = 3'b000;
            total++;
            if (ev_valid !== exp_v[i][0] || (exp_v[i][0] && ev_lane !== exp_l[i])) begin
                $display("FAIL all_lanes_step%0d: got v=%b l=%0d, want v=%b l=%0d",
                         i, ev_valid, ev_lane, exp_v[i][0], exp_l[i]);
            end else passed++;
        end
        for (int i = 0; i < 4; i++) begin
            cnt_sel = 2'(i);
            #1;
            total++;
            if (cnt_value !== ((i == 3) ? 8'd0 : 8'd1)) begin
                $display("FAIL all_lanes_cnt%0d: got %0d, want %0d",
                         i, cnt_value, (i == 3) ? 0 : 1);
            end else passed++;
        end
    endtask

    task automatic test_stall();
        ev_ready  = 1'b0;
        det_pulse = 3'b010;
        tick();
        det_pulse = 3'b000;
        tick();
        total++;
        if (ev_valid !== 1'b1 || ev_lane !== 2'd1) begin
            $display("FAIL stall_offer: got v=%b l=%0d, want v=1 l=1", ev_valid, ev_lane);
        end else passed++;
        for (int i = 0; i < 5; i++) begin
            det_pulse = (i == 1 || i == 3) ? 3'b010 : 3'b000;
            tick();
            det_pulse = 3'b000;
            total++;
            if (ev_valid !== 1'b1 || ev_lane !== 2'd1 ||
                ovf_flags !== ((i >= 3) ? 3'b010 : 3'b000)) begin
                $display("FAIL stall_hold%0d: got v=%b l=%0d ovf=%b, want v=1 l=1 ovf=%b",
                         i, ev_valid, ev_lane, ovf_flags, (i >= 3) ? 3'b010 : 3'b000);
            end else passed++;
        end
        ev_ready = 1'b1;
        tick();
        total++;
        if (ev_valid !== 1'b0) begin
            $display("FAIL stall_accept: got v=%b, want 0", ev_valid);
        end else passed++;
        tick();
        total++;
        if (ev_valid !== 1'b1 || ev_lane !== 2'd1) begin
            $display("FAIL stall_repend: got v=%b l=%0d, want v=1 l=1", ev_valid, ev_lane);
        end else passed++;
        tick();
        cnt_sel = 2'd1;
        #1;
        total++;
        if (ev_valid !== 1'b0 || cnt_value !== 8'd4) begin
            $display("FAIL stall_end: got v=%b cnt1=%0d, want v=0 cnt1=4", ev_valid, cnt_value);
        end else passed++;
    endtask

    task automatic test_disabled();
        apply_reset();
        lane_en   = 3'b101;
        ev_ready  = 1'b1;
        det_pulse = 3'b010;
        tick();
        det_pulse = 3'b000;
        total++;
        if (any_hit !== 1'b0) begin
            $display("FAIL disabled_anyhit: got %b, want 0", any_hit);
        end else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (ev_valid !== 1'b0) begin
                $display("FAIL disabled_valid%0d: got %b, want 0", i, ev_valid);
            end else passed++;
        end
        cnt_sel = 2'd1;
        #1;
        total++;
        if (cnt_value !== 8'd0) begin
            $display("FAIL disabled_cnt1: got %0d, want 0", cnt_value);
        end else passed++;
        lane_en = 3'b111;
    endtask

    task automatic test_saturate();
        ev_ready = 1'b1;
        cnt_sel  = 2'd2;
        for (int i = 0; i < 260; i++) begin
            det_pulse = 3'b100;
            tick();
        end
        det_pulse = 3'b000;
        for (int i = 0; i < 6; i++) tick();
        total++;
        if (cnt_value !== 8'd255 || ovf_flags !== 3'b100 || ev_valid !== 1'b0) begin
            $display("FAIL sat_cnt2: got cnt=%0d ovf=%b v=%b, want cnt=255 ovf=100 v=0",
                     cnt_value, ovf_flags, ev_valid);
        end else passed++;
        det_pulse = 3'b100;
        cnt_clear = 1'b1;
        tick();
        det_pulse = 3'b000;
        cnt_clear = 1'b0;
        total++;
        if (cnt_value !== 8'd0 || ovf_flags !== 3'b000 || any_hit !== 1'b1) begin
            $display("FAIL sat_clear: got cnt=%0d ovf=%b ah=%b, want cnt=0 ovf=000 ah=1",
                     cnt_value, ovf_flags, any_hit);
        end else passed++;
        tick();
        total++;
        if (ev_valid !== 1'b1 || ev_lane !== 2'd2) begin
            $display("FAIL sat_clear_event: got v=%b l=%0d, want v=1 l=2", ev_valid, ev_lane);
        end else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        ev_ready  = 1'b1;
        det_pulse = 3'b001;
        tick();
        det_pulse = 3'b000;
        tick();
        tick();
        ev_ready  = 1'b0;
        det_pulse = 3'b110;
        tick();
        det_pulse = 3'b001;
        tick();
        det_pulse = 3'b000;
        total++;
        if (ev_valid !== 1'b1 || ev_lane !== 2'd1) begin
            $display("FAIL rmid_offer: got v=%b l=%0d, want v=1 l=1", ev_valid, ev_lane);
        end else passed++;
        #1 reset = 1'b1;
        #1;
        total++;
        if (ev_valid !== 1'b0 || ev_lane !== 2'd0) begin
            $display("FAIL rmid_async: got v=%b l=%0d, want v=0 l=0", ev_valid, ev_lane);
        end else passed++;
        tick();
        tick();
        reset    = 1'b0;
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (ev_valid !== 1'b0) begin
                $display("FAIL rmid_quiet%0d: got v=%b, want 0", i, ev_valid);
            end else passed++;
        end
        det_pulse = 3'b011;
        tick();
        det_pulse = 3'b000;
        tick();
        total++;
        if (ev_valid !== 1'b1 || ev_lane !== 2'd0) begin
            $display("FAIL rmid_first: got v=%b l=%0d, want v=1 l=0", ev_valid, ev_lane);
        end else passed++;
    endtask

    initial begin
        reset     = 1'b1;
        lane_en   = 3'b111;
        det_pulse = 3'b000;
        ev_ready  = 1'b0;
        cnt_sel   = 2'd0;
        cnt_clear = 1'b0;
        test_reset();
        test_single();
        test_all_lanes();
        test_stall();
        test_disabled();
        test_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
